// File: rtl/uart_pkg.sv
// Shared definitions for the photo-frame serial link (uart_tx / uart_rx).
//   - default clock and line rate
//   - 3-bit FSM state encodings reported on o_state by both directions
//   - bit-period derivation used by the baud counters
package uart_pkg;

  localparam int unsigned DEF_CLK_FREQ  = 50_000_000;
  localparam int unsigned DEF_BAUD_RATE = 9600;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } uart_state_e;

  // Clocks per bit, rounded to nearest so the rate error stays below half a clock.
  function automatic int unsigned calc_bit_cnt(input int unsigned clk_freq,
                                               input int unsigned baud_rate);
    return (clk_freq + baud_rate / 2) / baud_rate;
  endfunction

  function automatic int unsigned calc_half_bit(input int unsigned clk_freq,
                                                input int unsigned baud_rate);
    return calc_bit_cnt(clk_freq, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side bundle between the serial line, uart_rx and the frame-buffer loader.
//   uart_rx    : serial line into the receiver (idle high)
//   data_rx    : last good byte
//   data_valid : one-cycle pulse when data_rx updates
//   frame_err  : one-cycle pulse on a bad stop bit
//   state      : receiver FSM state (debug)
//   busy       : receiver not idle
// master = line driver / byte consumer side, slave = receiver side.
interface uart_rx_if;
  logic       uart_rx;
  logic [7:0] data_rx;
  logic       data_valid;
  logic       frame_err;
  logic [2:0] state;
  logic       busy;

  modport master (
    output uart_rx,
    input  data_rx, data_valid, frame_err, state, busy
  );

  modport slave (
    input  uart_rx,
    output data_rx, data_valid, frame_err, state, busy
  );
endinterface

// File: rtl/uart_sync2.sv
// Generic two-flop synchronizer for a single asynchronous bit.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, loads RST_VAL into both stages
//   d_i   : asynchronous input
//   q_o   : synchronized output (two clock latency)
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: non-blocking assignments make both stages update from pre-edge values,
  // giving a real two-stage shift instead of a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver (LSB first, one start, eight data, one stop, no parity).
//   i_clk_sys    : system clock, rising edge
//   i_rst_n      : asynchronous active-low reset
//   i_uart_rx    : serial line, asynchronous, idle high
//   o_data_rx    : last correctly received byte, held until the next good frame
//   o_data_valid : one-cycle pulse when o_data_rx updates
//   o_frame_err  : one-cycle pulse when the stop bit samples 0
//   o_state      : current FSM state (debug)
//   o_busy       : high in every state except IDLE
// The start bit is re-checked at mid-bit, every later bit is sampled at its
// centre, and the FSM returns to IDLE at mid-stop-bit so back-to-back frames
// keep half a bit of margin for the next start edge.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = DEF_CLK_FREQ,
  parameter int unsigned BAUD_RATE = DEF_BAUD_RATE
) (
  input  logic       i_clk_sys,
  input  logic       i_rst_n,
  input  logic       i_uart_rx,
  output logic [7:0] o_data_rx,
  output logic       o_data_valid,
  output logic       o_frame_err,
  output logic [2:0] o_state,
  output logic       o_busy
);

  localparam int unsigned BIT_CNT  = calc_bit_cnt(CLK_FREQ, BAUD_RATE);
  localparam int unsigned HALF_BIT = calc_half_bit(CLK_FREQ, BAUD_RATE);
  localparam int unsigned CNT_W    = $clog2(BIT_CNT);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CNT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  logic rx_s;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (i_clk_sys),
    .rst_n (i_rst_n),
    .d_i   (i_uart_rx),
    .q_o   (rx_s)
  );

  uart_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       idx_q;
  logic [7:0]       shift_q;
  logic [7:0]       data_q;
  logic             valid_q;
  logic             err_q;

  // The counter is zeroed on every transition so each state times from its own entry.
  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: pulses default low every cycle so they can only be high for the
      // single cycle in which a branch below sets them.
      valid_q <= 1'b0;
      err_q   <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (!rx_s) begin
            state_q <= ST_START;
          end
        end

        ST_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            if (!rx_s) begin
              state_q <= ST_DATA;
              idx_q   <= '0;
            end else begin
              // Line went back high before mid-start: a glitch, not a frame.
              state_q <= ST_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q          <= '0;
            shift_q[idx_q] <= rx_s;
            if (idx_q == 3'd7) begin
              state_q <= ST_STOP;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q <= '0;
            if (rx_s) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              err_q   <= 1'b1;
              state_q <= ST_WAIT_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_WAIT_IDLE: begin
          // Hold off through a break until the line returns to idle.
          cnt_q <= '0;
          if (rx_s) begin
            state_q <= ST_IDLE;
          end
        end

        default: begin
          cnt_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_data_rx    = data_q;
  assign o_data_valid = valid_q;
  assign o_frame_err  = err_q;
  assign o_state      = state_q;
  assign o_busy       = (state_q != ST_IDLE);

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver for 8N1 frames: LSB first, one start bit, eight data bits, one stop bit, no parity. It is the downstream partner of `uart_tx` on the photo-frame's serial link. It recovers bytes from the host line `i_uart_rx` and hands each one to the frame-buffer loader as a one-cycle valid pulse. It validates start bits, samples each bit at mid-bit, and flags framing errors.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD_RATE`, default 9600: line rate in baud.
- `i_clk_sys`, input, 1: system clock, rising edge.
- `i_rst_n`, input, 1: reset, asynchronous, active-low.
- `i_uart_rx`, input, 1: serial line, asynchronous to `i_clk_sys`, idle high.
- `o_data_rx`, output, 8: last correctly received byte; held until the next good frame.
- `o_data_valid`, output, 1: one-cycle pulse when `o_data_rx` updates.
- `o_frame_err`, output, 1: one-cycle pulse when the stop bit samples 0.
- `o_state`, output, 3: current FSM state, for debug.
- `o_busy`, output, 1: high in every state except IDLE.

## Operation
- Synchronizer: `i_uart_rx` passes through 2 flops, reset value 1. All logic uses the synchronized `rx_s`.
- `BIT_CNT = (CLK_FREQ + BAUD_RATE/2) / BAUD_RATE`. This is 5208 at the defaults.
- `HALF_BIT = BIT_CNT / 2`. This is 2604 at the defaults.
- Baud counter width is `$clog2(BIT_CNT)`, 13 bits at the defaults. The counter is cleared on every state entry.
- States and encodings:
  - IDLE = 0: counter held at 0. When `rx_s` = 0, go to START.
  - START = 1: count to `HALF_BIT-1`, then sample `rx_s`.
    - Sample 0: valid start; go to DATA with bit index 0.
    - Sample 1: glitch; return to IDLE with no output pulse.
  - DATA = 2: count to `BIT_CNT-1`, then sample into shift register bit [index].
    - LSB is received first.
    - After index 7, go to STOP.
  - STOP = 3: count to `BIT_CNT-1`, then sample `rx_s`.
    - Sample 1: load `o_data_rx`, pulse `o_data_valid`, go to IDLE.
    - Sample 0: pulse `o_frame_err`, leave `o_data_rx` unchanged, go to WAIT_IDLE.
  - WAIT_IDLE = 4: stay until `rx_s` = 1, then go to IDLE. This covers break and resynchronization.
  - Codes 5–7 are illegal and return to IDLE next cycle.
- The return to IDLE happens at mid-stop-bit. The next start edge is therefore accepted with up to half a bit of margin, so back-to-back frames are supported.
- Reset values: `o_data_rx` = 8'h00, `o_data_valid` = 0, `o_frame_err` = 0, `o_state` = 0, `o_busy` = 0. The synchronizer, shift register and counters are also cleared.
- Reset asserted mid-frame aborts the frame immediately. After release, the block waits in IDLE for a new falling edge.
- A low line at reset release reads as a start bit. It is rejected only by the START mid-bit check, or by WAIT_IDLE after a framing error.
- `o_data_valid` and `o_frame_err` are never high in the same cycle.

## Timing
- Let cycle k be the first rising edge that samples `i_uart_rx` = 0. Then:
  - `rx_s` = 0 at k+2.
  - State = START at k+3.
  - Mid-start sample at k+3+`HALF_BIT`-1.
- `o_data_valid` or `o_frame_err` is registered. It is high for exactly one cycle, about `9*BIT_CNT + HALF_BIT + 3` cycles after k.
- Bench tolerance on that latency is ±2 cycles.
- Receive tolerance: correct reception for line bit-time error up to ±3 %.

## Structure
- Shared package `uart_pkg` holds:
  - default `CLK_FREQ` and `BAUD_RATE`;
  - the 3-bit state encodings, common to `uart_tx` and `uart_rx` `o_state`;
  - the `BIT_CNT` and `HALF_BIT` derivation.
- Sub-module `uart_sync2`: generic 2-flop synchronizer with parameterized reset value, instantiated once. The rest is one FSM and a datapath in `uart_rx`.

## Test plan
- Idle, then bench drives 0x5A at 5208 clk/bit -> one `o_data_valid` pulse, `o_data_rx` = 8'h5A, `o_frame_err` never high, latency within ±2 of spec.
- Low glitch of 1000 clks on an idle line -> state returns to 0 after `HALF_BIT` cycles, no valid or error pulse, `o_data_rx` unchanged.
- After 0x5A, drive 0xA5 with stop bit 0, line held low for 2 bit times -> one `o_frame_err` pulse, `o_data_rx` stays 8'h5A, state 4 until line high, then 0.
- Back-to-back 0x00 then 0xFF with single stop bits -> two valid pulses, values 8'h00 then 8'hFF.
- Reset pulse during data bit 3 of 0x77 -> all outputs at reset values, no pulse. After release and 1 idle bit time, 0x3C is received correctly.
- 0x81 sent at 5312 clk/bit (+2 %) and again at 5104 clk/bit (−2 %) -> both received as 8'h81 with no framing error.
